// File: rtl/rv32i_fetch_ctrl_pkg.sv
// rtl/rv32i_fetch_ctrl_pkg.sv - shared types and constants for the instruction fetch sequencer
package rv32i_fetch_ctrl_pkg;

    localparam int          INST_WIDTH       = 32;
    localparam int          ADDR_WIDTH       = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_FLUSH = 2'd1,
        ST_ERR   = 2'd2
    } fetch_state_e;

    function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv32i_fetch_skid.sv
// rtl/rv32i_fetch_skid.sv - one-entry {inst,pc} holding buffer for responses that land during a stall
module rv32i_fetch_skid
    import rv32i_fetch_ctrl_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  wr_i,
    input  logic                  rd_i,
    input  logic                  clear_i,
    input  logic [INST_WIDTH-1:0] inst_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  full_o
);

    logic [INST_WIDTH-1:0] inst_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  full_q;

    // A write in the same cycle as a read replaces the drained entry, so write wins.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            inst_q <= '0;
            pc_q   <= '0;
            full_q <= 1'b0;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end else if (wr_i) begin
            inst_q <= inst_i;
            pc_q   <= pc_i;
            full_q <= 1'b1;
        end else if (rd_i) begin
            full_q <= 1'b0;
        end
    end

    assign inst_o = inst_q;
    assign pc_o   = pc_q;
    assign full_o = full_q;

endmodule

// File: rtl/rv32i_fetch_ctrl.sv
// rtl/rv32i_fetch_ctrl.sv - PC owner and single-outstanding fetch sequencer with redirect, flush and timeout
module rv32i_fetch_ctrl
    import rv32i_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic [ADDR_WIDTH-1:0] o_iaddr,
    output logic                  o_stb,
    input  logic                  i_ack,
    input  logic [INST_WIDTH-1:0] i_inst,
    input  logic                  i_stall,
    input  logic                  i_change_pc,
    input  logic [ADDR_WIDTH-1:0] i_new_pc,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic                  o_ce,
    output logic                  o_bus_err
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] iaddr_q, iaddr_d;
    logic                  stb_q, stb_d;
    logic                  ce_q, ce_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] opc_q, opc_d;
    logic                  err_q, err_d;
    logic [15:0]           cnt_q, cnt_d;

    logic                  skid_wr, skid_rd, skid_clear, skid_full, skid_full_next;
    logic [INST_WIDTH-1:0] skid_inst;
    logic [ADDR_WIDTH-1:0] skid_pc;
    logic                  consume, ack, waiting, timeout_hit;

    assign consume     = ce_q && !i_stall;
    assign ack         = stb_q && i_ack;
    assign waiting     = stb_q && !i_ack;
    assign timeout_hit = waiting && (cnt_q >= TO_LAST);

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        iaddr_d        = iaddr_q;
        stb_d          = stb_q;
        ce_d           = ce_q;
        inst_d         = inst_q;
        opc_d          = opc_q;
        err_d          = err_q;
        cnt_d          = waiting ? cnt_q + 16'd1 : 16'd0;
        skid_wr        = 1'b0;
        skid_rd        = 1'b0;
        skid_clear     = 1'b0;
        skid_full_next = skid_full;

        if (i_change_pc) begin
            pc_d       = align_pc(i_new_pc);
            ce_d       = 1'b0;
            skid_clear = 1'b1;
            err_d      = 1'b0;
            // A request still on the bus must complete before the new PC can be issued.
            if (waiting) begin
                state_d = ST_FLUSH;
            end else begin
                state_d = ST_FETCH;
                stb_d   = 1'b1;
                iaddr_d = pc_d;
            end
        end else if (timeout_hit) begin
            state_d    = ST_ERR;
            stb_d      = 1'b0;
            ce_d       = 1'b0;
            err_d      = 1'b1;
            skid_clear = 1'b1;
            cnt_d      = 16'd0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (consume) begin
                        if (skid_full) begin
                            inst_d  = skid_inst;
                            opc_d   = skid_pc;
                            skid_rd = 1'b1;
                            skid_wr = ack;
                        end else if (ack) begin
                            inst_d = i_inst;
                            opc_d  = iaddr_q;
                        end
                        ce_d = skid_full || ack;
                    end else if (ack) begin
                        if (!ce_q) begin
                            inst_d = i_inst;
                            opc_d  = iaddr_q;
                            ce_d   = 1'b1;
                        end else begin
                            skid_wr = 1'b1;
                        end
                    end
                    if (ack) begin
                        pc_d = pc_q + PC_STEP;
                    end
                    skid_full_next = skid_wr || (skid_full && !skid_rd);
                    // Only issue when a landing response is guaranteed a place to go.
                    if (!waiting) begin
                        stb_d   = !skid_full_next;
                        iaddr_d = pc_d;
                    end
                end
                ST_FLUSH: begin
                    if (ack) begin
                        state_d = ST_FETCH;
                        stb_d   = 1'b1;
                        iaddr_d = pc_q;
                    end
                end
                ST_ERR: begin
                    stb_d = 1'b0;
                    ce_d  = 1'b0;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            iaddr_q <= RESET_PC;
            stb_q   <= 1'b0;
            ce_q    <= 1'b0;
            inst_q  <= '0;
            opc_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            iaddr_q <= iaddr_d;
            stb_q   <= stb_d;
            ce_q    <= ce_d;
            inst_q  <= inst_d;
            opc_q   <= opc_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    rv32i_fetch_skid u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .wr_i    (skid_wr),
        .rd_i    (skid_rd),
        .clear_i (skid_clear),
        .inst_i  (i_inst),
        .pc_i    (iaddr_q),
        .inst_o  (skid_inst),
        .pc_o    (skid_pc),
        .full_o  (skid_full)
    );

    assign o_iaddr   = iaddr_q;
    assign o_stb     = stb_q;
    assign o_ce      = ce_q;
    assign o_inst    = inst_q;
    assign o_pc      = opc_q;
    assign o_bus_err = err_q;

endmodule

// File: tb/tb_rv32i_fetch_ctrl.sv
// tb/tb_rv32i_fetch_ctrl.sv - directed self-checking bench for the fetch sequencer
module tb_rv32i_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] o_iaddr;
    logic        o_stb;
    logic        i_ack;
    logic [31:0] i_inst;
    logic        i_stall;
    logic        i_change_pc;
    logic [31:0] i_new_pc;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        o_ce;
    logic        o_bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Memory returns a word derived from its address.
    assign i_inst = o_iaddr ^ 32'hDEAD_0000;

    rv32i_fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .o_iaddr     (o_iaddr),
        .o_stb       (o_stb),
        .i_ack       (i_ack),
        .i_inst      (i_inst),
        .i_stall     (i_stall),
        .i_change_pc (i_change_pc),
        .i_new_pc    (i_new_pc),
        .o_inst      (o_inst),
        .o_pc        (o_pc),
        .o_ce        (o_ce),
        .o_bus_err   (o_bus_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        i_ack       = 1'b0;
        i_stall     = 1'b0;
        i_change_pc = 1'b0;
        i_new_pc    = 32'h0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        i_ack       = 1'b0;
        i_stall     = 1'b0;
        i_change_pc = 1'b0;
        i_new_pc    = 32'h0;
        step();
        step();
        n_tests++;
        if ({o_stb, o_ce, o_bus_err, o_iaddr, o_pc, o_inst} !== {3'b000, 32'h0, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_state got stb=%b ce=%b err=%b iaddr=%h pc=%h inst=%h exp all zero",
                     o_stb, o_ce, o_bus_err, o_iaddr, o_pc, o_inst);
        end
        rst_n = 1'b1;
        step();
        n_tests++;
        if ({o_stb, o_ce, o_iaddr} !== {2'b10, 32'h0}) begin
            n_fail++;
            $display("FAIL first_stb got stb=%b ce=%b iaddr=%h exp stb=1 ce=0 iaddr=0", o_stb, o_ce, o_iaddr);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        i_ack = 1'b1;
        step();
        n_tests++;
        if ({o_stb, o_ce, o_iaddr} !== {2'b10, 32'h0}) begin
            n_fail++;
            $display("FAIL zw_issue got stb=%b ce=%b iaddr=%h exp stb=1 ce=0 iaddr=0", o_stb, o_ce, o_iaddr);
        end
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'(k * 4);
            step();
            n_tests++;
            if ({o_ce, o_pc, o_inst} !== {1'b1, exp_pc, exp_pc ^ 32'hDEAD_0000}) begin
                n_fail++;
                $display("FAIL zw_stream%0d got ce=%b pc=%h inst=%h exp ce=1 pc=%h inst=%h",
                         k, o_ce, o_pc, o_inst, exp_pc, exp_pc ^ 32'hDEAD_0000);
            end
        end
    endtask

    task automatic test_stall_skid();
        do_reset();
        step();
        i_ack = 1'b1;
        step();
        i_stall = 1'b1;
        step();
        n_tests++;
        if ({o_stb, o_ce, o_pc, o_iaddr} !== {2'b01, 32'h0, 32'h8}) begin
            n_fail++;
            $display("FAIL stall_capture got stb=%b ce=%b pc=%h iaddr=%h exp stb=0 ce=1 pc=0 iaddr=8",
                     o_stb, o_ce, o_pc, o_iaddr);
        end
        step();
        n_tests++;
        if ({o_stb, o_ce, o_pc, o_inst} !== {2'b01, 32'h0, 32'hDEAD_0000}) begin
            n_fail++;
            $display("FAIL stall_hold got stb=%b ce=%b pc=%h inst=%h exp stb=0 ce=1 pc=0 inst=dead0000",
                     o_stb, o_ce, o_pc, o_inst);
        end
        i_stall = 1'b0;
        step();
        n_tests++;
        if ({o_ce, o_pc, o_inst, o_stb, o_iaddr} !== {1'b1, 32'h4, 32'hDEAD_0004, 1'b1, 32'h8}) begin
            n_fail++;
            $display("FAIL skid_drain got ce=%b pc=%h inst=%h stb=%b iaddr=%h exp ce=1 pc=4 inst=dead0004 stb=1 iaddr=8",
                     o_ce, o_pc, o_inst, o_stb, o_iaddr);
        end
        step();
        n_tests++;
        if ({o_ce, o_pc, o_inst} !== {1'b1, 32'h8, 32'hDEAD_0008}) begin
            n_fail++;
            $display("FAIL back_to_back got ce=%b pc=%h inst=%h exp ce=1 pc=8 inst=dead0008", o_ce, o_pc, o_inst);
        end
    endtask

    task automatic test_flush();
        do_reset();
        step();
        step();
        step();
        i_change_pc = 1'b1;
        i_new_pc    = 32'h100;
        step();
        i_change_pc = 1'b0;
        n_tests++;
        if ({o_stb, o_ce, o_iaddr} !== {2'b10, 32'h0}) begin
            n_fail++;
            $display("FAIL flush_hold got stb=%b ce=%b iaddr=%h exp stb=1 ce=0 iaddr=0", o_stb, o_ce, o_iaddr);
        end
        step();
        i_ack = 1'b1;
        step();
        n_tests++;
        if ({o_stb, o_ce, o_iaddr} !== {2'b10, 32'h100}) begin
            n_fail++;
            $display("FAIL flush_drop got stb=%b ce=%b iaddr=%h exp stb=1 ce=0 iaddr=100", o_stb, o_ce, o_iaddr);
        end
        step();
        n_tests++;
        if ({o_ce, o_pc, o_inst} !== {1'b1, 32'h100, 32'hDEAD_0100}) begin
            n_fail++;
            $display("FAIL flush_resume got ce=%b pc=%h inst=%h exp ce=1 pc=100 inst=dead0100", o_ce, o_pc, o_inst);
        end
    endtask

    task automatic test_redirect_with_ack();
        do_reset();
        i_ack = 1'b1;
        step();
        step();
        i_change_pc = 1'b1;
        i_new_pc    = 32'h203;
        step();
        i_change_pc = 1'b0;
        n_tests++;
        if ({o_stb, o_ce, o_iaddr} !== {2'b10, 32'h200}) begin
            n_fail++;
            $display("FAIL redir_ack got stb=%b ce=%b iaddr=%h exp stb=1 ce=0 iaddr=200", o_stb, o_ce, o_iaddr);
        end
        step();
        n_tests++;
        if ({o_ce, o_pc, o_inst} !== {1'b1, 32'h200, 32'hDEAD_0200}) begin
            n_fail++;
            $display("FAIL redir_first got ce=%b pc=%h inst=%h exp ce=1 pc=200 inst=dead0200", o_ce, o_pc, o_inst);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        step();
        for (int k = 0; k < 7; k++) step();
        n_tests++;
        if ({o_bus_err, o_stb} !== 2'b01) begin
            n_fail++;
            $display("FAIL to_early got err=%b stb=%b exp err=0 stb=1", o_bus_err, o_stb);
        end
        step();
        n_tests++;
        if ({o_bus_err, o_stb, o_ce} !== 3'b100) begin
            n_fail++;
            $display("FAIL to_fire got err=%b stb=%b ce=%b exp err=1 stb=0 ce=0", o_bus_err, o_stb, o_ce);
        end
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        n_tests++;
        if ({o_bus_err, o_stb, o_ce} !== 3'b100) begin
            n_fail++;
            $display("FAIL to_late_ack got err=%b stb=%b ce=%b exp err=1 stb=0 ce=0", o_bus_err, o_stb, o_ce);
        end
        i_change_pc = 1'b1;
        i_new_pc    = 32'h40;
        step();
        i_change_pc = 1'b0;
        n_tests++;
        if ({o_bus_err, o_stb, o_iaddr} !== {2'b01, 32'h40}) begin
            n_fail++;
            $display("FAIL to_clear got err=%b stb=%b iaddr=%h exp err=0 stb=1 iaddr=40", o_bus_err, o_stb, o_iaddr);
        end
        i_ack = 1'b1;
        step();
        n_tests++;
        if ({o_ce, o_pc} !== {1'b1, 32'h40}) begin
            n_fail++;
            $display("FAIL to_resume got ce=%b pc=%h exp ce=1 pc=40", o_ce, o_pc);
        end
    endtask

    task automatic test_wrap_and_reset_mid();
        do_reset();
        step();
        i_change_pc = 1'b1;
        i_new_pc    = 32'hFFFF_FFFC;
        i_ack       = 1'b1;
        step();
        i_change_pc = 1'b0;
        n_tests++;
        if ({o_stb, o_iaddr} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_fail++;
            $display("FAIL wrap_issue got stb=%b iaddr=%h exp stb=1 iaddr=fffffffc", o_stb, o_iaddr);
        end
        step();
        n_tests++;
        if ({o_ce, o_pc, o_inst, o_iaddr} !== {1'b1, 32'hFFFF_FFFC, 32'h2152_FFFC, 32'h0}) begin
            n_fail++;
            $display("FAIL wrap_next got ce=%b pc=%h inst=%h iaddr=%h exp ce=1 pc=fffffffc inst=2152fffc iaddr=0",
                     o_ce, o_pc, o_inst, o_iaddr);
        end
        i_ack = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        n_tests++;
        if ({o_stb, o_ce, o_bus_err, o_iaddr, o_pc, o_inst} !== {3'b000, 32'h0, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_mid got stb=%b ce=%b err=%b iaddr=%h pc=%h inst=%h exp all zero",
                     o_stb, o_ce, o_bus_err, o_iaddr, o_pc, o_inst);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall_skid();
        test_flush();
        test_redirect_with_ack();
        test_timeout();
        test_wrap_and_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
